// File: rtl/compress_feed_ctrl.sv
// Stream-side controller for the eight-word compressor: gathers words into blocks,
// paces the compressor pipeline with wrtEn and tracks real blocks to a valid/ready output.
module compress_feed_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8,
  parameter int TAG_WIDTH  = 2,
  parameter int LEN_WIDTH  = 8,
  parameter int PIPE_DEPTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_last,
  output logic                            cu_wrtEn,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] cu_dataIn,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] cu_dataOut,
  input  logic [TAG_WIDTH*NUM_WORDS-1:0]  cu_tagOut,
  input  logic [LEN_WIDTH-1:0]            cu_lenOut,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] out_data,
  output logic [TAG_WIDTH*NUM_WORDS-1:0]  out_tag,
  output logic [LEN_WIDTH-1:0]            out_len,
  output logic [3:0]                      out_nwords,
  output logic                            out_last,
  output logic [CNT_WIDTH-1:0]            blk_count
);

  localparam int BLK_W = DATA_WIDTH * NUM_WORDS;
  localparam int IDX_W = $clog2(NUM_WORDS);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t             state_r;
  state_t             nextState_s;
  logic [IDX_W-1:0]   wordCnt_r;
  logic [IDX_W-1:0]   nextWordCnt_s;
  logic [BLK_W-1:0]   blkBuf_r;
  logic [BLK_W-1:0]   nextBlkBuf_s;
  logic [3:0]         pendNw_r;
  logic [3:0]         nextPendNw_s;
  logic               pendLast_r;
  logic               nextPendLast_s;
  logic [PIPE_DEPTH-1:0] vld_r;
  logic [PIPE_DEPTH-1:0] lst_r;
  logic [3:0]         nw_r [PIPE_DEPTH];
  logic [CNT_WIDTH-1:0] blkCount_r;
  logic               wrtEn_s;
  logic               accept_s;
  logic               lastSlot_s;
  logic               blockReady_s;
  logic               deliver_s;

  // Write one word into its slot of the block buffer, leaving other slots untouched.
  function automatic logic [BLK_W-1:0] insertWord(
    input logic [BLK_W-1:0]      blk,
    input logic [DATA_WIDTH-1:0] word,
    input logic [IDX_W-1:0]      idx
  );
    logic [BLK_W-1:0] res;
    res = blk;
    res[int'(idx)*DATA_WIDTH +: DATA_WIDTH] = word;
    return res;
  endfunction

  // Handshake and pipeline-advance qualifiers.
  always_comb begin
    blockReady_s = (state_r == FULL);
    accept_s     = in_valid && (state_r == FILL);
    lastSlot_s   = (wordCnt_r == IDX_W'(NUM_WORDS - 1));
    wrtEn_s      = !vld_r[PIPE_DEPTH-1] || out_ready;
    deliver_s    = vld_r[PIPE_DEPTH-1] && out_ready;
  end

  // Gather FSM next-state: fill slots, close the block, then release it on wrtEn.
  always_comb begin
    nextState_s    = state_r;
    nextWordCnt_s  = wordCnt_r;
    nextBlkBuf_s   = blkBuf_r;
    nextPendNw_s   = pendNw_r;
    nextPendLast_s = pendLast_r;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          nextBlkBuf_s = insertWord(blkBuf_r, in_data, wordCnt_r);
          if (lastSlot_s || in_last) begin
            nextState_s    = FULL;
            nextPendNw_s   = 4'(wordCnt_r) + 4'd1;
            nextPendLast_s = in_last;
          end else begin
            nextWordCnt_s = wordCnt_r + IDX_W'(1);
          end
        end else begin
          nextState_s = FILL;
        end
      end
      FULL: begin
        // Clearing the buffer on release is what zero-pads the next partial block.
        if (wrtEn_s) begin
          nextState_s    = FILL;
          nextWordCnt_s  = '0;
          nextBlkBuf_s   = '0;
          nextPendNw_s   = 4'd0;
          nextPendLast_s = 1'b0;
        end else begin
          nextState_s = FULL;
        end
      end
      default: begin
        nextState_s    = FILL;
        nextWordCnt_s  = '0;
        nextBlkBuf_s   = '0;
        nextPendNw_s   = 4'd0;
        nextPendLast_s = 1'b0;
      end
    endcase
  end

  // Gather FSM state, slot counter, block buffer and pending block flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= FILL;
      wordCnt_r  <= '0;
      blkBuf_r   <= '0;
      pendNw_r   <= 4'd0;
      pendLast_r <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      wordCnt_r  <= nextWordCnt_s;
      blkBuf_r   <= nextBlkBuf_s;
      pendNw_r   <= nextPendNw_s;
      pendLast_r <= nextPendLast_s;
    end
  end

  // Slot tracking that mirrors the compressor stages; bubbles travel with vld=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_r <= '0;
      lst_r <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        nw_r[i] <= 4'd0;
      end
    end else if (wrtEn_s) begin
      vld_r   <= {vld_r[PIPE_DEPTH-2:0], blockReady_s};
      lst_r   <= {lst_r[PIPE_DEPTH-2:0], pendLast_r};
      nw_r[0] <= pendNw_r;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        nw_r[i] <= nw_r[i-1];
      end
    end else begin
      vld_r <= vld_r;
      lst_r <= lst_r;
    end
  end

  // Delivered-block counter, wrapping naturally at its width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blkCount_r <= '0;
    end else if (deliver_s) begin
      blkCount_r <= blkCount_r + CNT_WIDTH'(1);
    end else begin
      blkCount_r <= blkCount_r;
    end
  end

  assign in_ready   = (state_r == FILL);
  assign cu_wrtEn   = wrtEn_s;
  assign cu_dataIn  = blkBuf_r;
  assign out_valid  = vld_r[PIPE_DEPTH-1];
  assign out_last   = lst_r[PIPE_DEPTH-1];
  assign out_nwords = nw_r[PIPE_DEPTH-1];
  assign out_data   = cu_dataOut;
  assign out_tag    = cu_tagOut;
  assign out_len    = cu_lenOut;
  assign blk_count  = blkCount_r;

endmodule

// File: doc/compress_feed_ctrl.md
Name: compress_feed_ctrl

Overview:
Stream-side controller for the eight-word compressor datapath.
- Gathers a stream of 32-bit words into 8-word blocks and presents each block to the compressor.
- Drives the compressor's global write enable (wrtEn) as a pipeline advance/stall signal.
- Tracks which pipeline slots hold real blocks and exposes compressed results with a valid/ready handshake.
- Supports partial (flushed) blocks through a last marker with zero padding.

Parameters:
DATA_WIDTH, 32, width of one input word / compressor lane
NUM_WORDS, 8, words per block (matches compressor unit count)
TAG_WIDTH, 2, per-word tag width
LEN_WIDTH, 8, compressed-length field width
PIPE_DEPTH, 5, number of wrtEn-gated register stages from compressor dataIn to dataOut/tagOut/lenOut
CNT_WIDTH, 16, width of completed-block counter

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  controller accepts input word
in_data  in  DATA_WIDTH  input word
in_last  in  1  final word of stream; closes current block early
cu_wrtEn  out  1  compressor pipeline advance enable
cu_dataIn  out  DATA_WIDTH*NUM_WORDS  block to compressor; word k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
cu_dataOut  in  DATA_WIDTH*NUM_WORDS  compressor packed data
cu_tagOut  in  TAG_WIDTH*NUM_WORDS  compressor tags
cu_lenOut  in  LEN_WIDTH  compressor length
out_valid  out  1  compressed block available
out_ready  in  1  downstream accepts block
out_data  out  DATA_WIDTH*NUM_WORDS  = cu_dataOut
out_tag  out  TAG_WIDTH*NUM_WORDS  = cu_tagOut
out_len  out  LEN_WIDTH  = cu_lenOut
out_nwords  out  4  real (non-pad) words in block, 1..8
out_last  out  1  block closed by in_last
blk_count  out  CNT_WIDTH  blocks delivered since reset

Behaviour:
- Reset, asynchronous, any cycle including mid-block:
  - state=FILL, word counter=0, block buffer=0.
  - valid/last/nwords shift registers cleared.
  - blk_count=0, out_valid=0, in_ready=1, cu_wrtEn=1.
  - Partially gathered words and in-flight blocks are discarded.
- FSM states:
  - FILL: in_ready=1. On in_valid, the word is written to slot[cnt] and cnt increments.
  - FILL to FULL: when the accepted word is slot 7 (cnt==7), or in_last=1 is accepted. The block's nwords is cnt+1, and its last flag equals in_last.
  - FULL: in_ready=0; buffer held on cu_dataIn.
  - FULL to FILL: on the cycle cu_wrtEn=1. That cycle the block enters the pipeline, then buffer, cnt and pending flags clear to 0. Zero-clear gives zero padding for partial blocks.
  - No bypass: in_ready stays 0 for the whole FULL cycle, even if the block is released that cycle.
- Pipeline tracking:
  - Shift registers vld/lst/nw are each PIPE_DEPTH long.
  - When cu_wrtEn=1: vld[0] <= (state==FULL), and lst[0]/nw[0] take the block's flags. Stages i>0 take stage i-1.
  - When cu_wrtEn=0: all stages hold.
  - Bubbles advance through the compressor as don't-care data with vld=0.
- Output:
  - out_valid = vld[PIPE_DEPTH-1].
  - out_last and out_nwords come from the tail stage.
  - out_data, out_tag and out_len pass straight through from the compressor.
- Stall rule:
  - cu_wrtEn = !out_valid || out_ready, combinational.
  - While out_valid=1 and out_ready=0, the whole pipeline and the FULL buffer freeze, so compressor outputs stay stable.
  - out_* must not change while out_valid=1 and out_ready=0.
- Latency: a block released at cycle T appears with out_valid=1 at T+PIPE_DEPTH, given no stalls.
- Throughput: one block per 9 cycles at full input rate (8 FILL cycles + 1 FULL cycle).
- blk_count:
  - Increments on out_valid && out_ready.
  - Wraps from 2^CNT_WIDTH-1 to 0.
- Simultaneous events:
  - A block release (FULL with cu_wrtEn=1) in the same cycle as tail acceptance is legal and counts both.
  - in_last on the 8th word gives nwords=8, last=1.
  - in_valid while in FULL is ignored (no accept).

Test Plan:
- Basic block: feed words 1..8 back-to-back, out_ready=1 -> release at cycle 8 (FULL). out_valid=1 exactly PIPE_DEPTH cycles later with out_nwords=8, out_last=0; blk_count=1; in_ready low for exactly 1 cycle.
- Partial flush: feed 3 words, the 3rd with in_last=1 -> out_nwords=3, out_last=1. cu_dataIn words 3..7 are 0 at release. The next block starts at slot 0.
- Back-pressure: 3 blocks queued, out_ready=0 for 20 cycles -> cu_wrtEn=0 and out_data/out_tag/out_len stable. Input stalls (in_ready=0) once FULL. After out_ready=1, 3 blocks are delivered in order and blk_count=3.
- Reset mid-operation: assert reset after 5 words with 2 blocks in flight -> out_valid=0, in_ready=1, blk_count=0 immediately (asynchronous). The next 8 words produce exactly one block.
- Counter wrap: CNT_WIDTH=4, deliver 17 blocks -> blk_count reads 15 then 0 then 1.
- Random valid/ready toggling over 1000 words with in_last every 13 words -> scoreboard matches nwords/last per block. No block is lost or duplicated.
